// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_arbiter : two-port arbiter (CPU / loader) onto single-port data RAM    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter bit RR_EN    = 1'b1,
  parameter int LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);

  logic       r_last;
  logic       r_owner_vld;
  logic       r_owner;
  logic [7:0] r_lock_cnt;
  logic [1:0] r_rd_pend;
  logic [1:0] r_err_pend;

  logic        w_owner_req;
  logic        w_other_req;
  logic        w_locked;
  logic        w_force;
  logic        w_any;
  logic        w_win;
  logic [31:0] w_addr;
  logic        w_we;
  logic        w_lock;
  logic        w_legal;

  assign w_owner_req = r_owner ? p1_req : p0_req;
  assign w_other_req = r_owner ? p0_req : p1_req;
  assign w_locked    = r_owner_vld & w_owner_req;
  assign w_force     = w_locked & (r_lock_cnt == c_lock_max) & w_other_req;

  always_comb begin
    w_any = 1'b0;
    w_win = 1'b0;
    if (!reset) begin
      if (w_locked && !w_force) begin
        w_any = 1'b1;
        w_win = r_owner;
      end else if (w_force) begin
        w_any = 1'b1;
        w_win = ~r_owner;
      end else if (p0_req && p1_req) begin
        w_any = 1'b1;
        w_win = RR_EN ? ~r_last : 1'b0;
      end else if (p0_req) begin
        w_any = 1'b1;
        w_win = 1'b0;
      end else if (p1_req) begin
        w_any = 1'b1;
        w_win = 1'b1;
      end
    end
  end

  // With no grant w_win stays 0, so the RAM bus idles on port 0's values.
  assign w_addr  = w_win ? p1_addr : p0_addr;
  assign w_we    = w_win ? p1_we   : p0_we;
  assign w_lock  = w_win ? p1_lock : p0_lock;
  assign w_legal = (w_addr[1:0] == 2'b00) && (w_addr[31:ADDR_W+2] == '0);

  assign p0_gnt   = w_any & ~w_win;
  assign p1_gnt   = w_any &  w_win;
  assign ram_we   = w_any & w_we & w_legal;
  assign ram_addr = w_addr[ADDR_W+1:2];
  assign ram_din  = w_win ? p1_wdata : p0_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_owner_vld <= 1'b0;
      r_owner     <= 1'b0;
      r_lock_cnt  <= 8'd0;
      r_rd_pend   <= 2'b00;
      r_err_pend  <= 2'b00;
    end else begin
      r_rd_pend  <= {p1_gnt & ~p1_we, p0_gnt & ~p0_we};
      r_err_pend <= {p1_gnt & ~w_legal, p0_gnt & ~w_legal};
      if (w_any) begin
        r_last <= w_win;
        if (w_lock) begin
          r_owner     <= w_win;
          r_owner_vld <= 1'b1;
          if (r_owner_vld && (r_owner == w_win)) begin
            if (r_lock_cnt < c_lock_max) r_lock_cnt <= r_lock_cnt + 8'd1;
          end else begin
            r_lock_cnt <= 8'd1;
          end
        end else begin
          r_owner_vld <= 1'b0;
          r_lock_cnt  <= 8'd0;
        end
      end else begin
        // No grant implies nobody (including any owner) is requesting.
        r_owner_vld <= 1'b0;
        r_lock_cnt  <= 8'd0;
      end
    end
  end

  // An illegal read still returns rvalid, but with zeroed data.
  assign p0_rvalid = r_rd_pend[0];
  assign p1_rvalid = r_rd_pend[1];
  assign p0_rdata  = (r_rd_pend[0] & ~r_err_pend[0]) ? ram_dout : 32'd0;
  assign p1_rdata  = (r_rd_pend[1] & ~r_err_pend[1]) ? ram_dout : 32'd0;
  assign p0_err    = r_err_pend[0];
  assign p1_err    = r_err_pend[1];

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_arbiter : self-checking bench with read-data scoreboard            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic        f0_gnt, f0_rvalid, f0_err, f1_gnt, f1_rvalid, f1_err;
  logic [31:0] f0_rdata, f1_rdata, f_din;
  logic        f_we;
  logic [13:0] f_addr;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit mon_off = 1'b1;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:16383];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  dmem_arbiter #(.ADDR_W(14), .RR_EN(1'b1), .LOCK_MAX(16)) dut (
    .clock(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  dmem_arbiter #(.ADDR_W(14), .RR_EN(1'b0), .LOCK_MAX(16)) dut_fp (
    .clock(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(f0_gnt), .p0_rvalid(f0_rvalid), .p0_rdata(f0_rdata), .p0_err(f0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(f1_gnt), .p1_rvalid(f1_rvalid), .p1_rdata(f1_rdata), .p1_err(f1_err),
    .ram_we(f_we), .ram_addr(f_addr), .ram_din(f_din), .ram_dout(ram_dout)
  );

  // Read-data scoreboard: every cycle the rvalid/rdata pair must match the queue head.
  exp_t        m_e;
  logic [1:0]  m_ev;
  logic [31:0] m_d0, m_d1;
  always @(negedge clk) begin
    if (!mon_off) begin
      m_ev = 2'b00; m_d0 = 32'd0; m_d1 = 32'd0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
        m_e = exp_q.pop_front();
        if (m_e.port == 0) begin m_ev[0] = 1'b1; m_d0 = m_e.data; end
        else begin m_ev[1] = 1'b1; m_d1 = m_e.data; end
      end
      checks++;
      if ({p1_rvalid, p0_rvalid} !== m_ev || p0_rdata !== m_d0 || p1_rdata !== m_d1) begin
        errors++;
        $display("FAIL rd_scoreboard cyc=%0d: rvalid=%b rdata0=%h rdata1=%h, required rvalid=%b rdata0=%h rdata1=%h",
                 cyc_n, {p1_rvalid, p0_rvalid}, p0_rdata, p1_rdata, m_ev, m_d0, m_d1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    p0_req = 1; p1_req = 1; p0_addr = 32'h10; p1_addr = 32'h20;
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if ({p1_gnt, p0_gnt, f1_gnt, f0_gnt, ram_we} !== 5'b0) begin
      errors++; $display("FAIL reset_gnt: got %b, required 00000", {p1_gnt, p0_gnt, f1_gnt, f0_gnt, ram_we});
    end
    checks++;
    if ({p1_rvalid, p0_rvalid, p1_err, p0_err} !== 4'b0 || p0_rdata !== 0 || p1_rdata !== 0) begin
      errors++; $display("FAIL reset_out: rv/err=%b rdata0=%h rdata1=%h, required 0", {p1_rvalid, p0_rvalid, p1_err, p0_err}, p0_rdata, p1_rdata);
    end
    cyc(); reset = 1'b0; idle();
    cyc();
    mon_off = 1'b0;
  endtask

  task automatic test_single_read();
    cyc(); p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    exp_q.push_back('{0, 32'hDEADBEEF, cyc_n + 1});
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      errors++; $display("FAIL single_gnt: got p0=%b p1=%b, required p0=1 p1=0", p0_gnt, p1_gnt);
    end
    checks++;
    if (ram_addr !== 14'd4 || ram_we !== 1'b0) begin
      errors++; $display("FAIL single_ram: got addr=%0d we=%b, required addr=4 we=0", ram_addr, ram_we);
    end
    cyc(); idle();
    cyc();
  endtask

  task automatic test_write_read();
    cyc(); p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 14'd8 || ram_din !== 32'h12345678) begin
      errors++; $display("FAIL wr_bus: got gnt=%b we=%b addr=%0d din=%h, required 1 1 8 12345678", p0_gnt, ram_we, ram_addr, ram_din);
    end
    cyc(); p0_we = 0; p0_wdata = 0;
    exp_q.push_back('{0, 32'h12345678, cyc_n + 1});
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1) begin
      errors++; $display("FAIL rd_after_wr_gnt: got %b, required 1", p0_gnt);
    end
    cyc(); idle();
    cyc();
  endtask

  task automatic test_errors();
    cyc(); p0_req = 1; p0_we = 1; p0_addr = 32'h0001_0000; p0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1 || ram_we !== 1'b0) begin
      errors++; $display("FAIL err_wr_bus: got gnt=%b we=%b, required gnt=1 we=0", p0_gnt, ram_we);
    end
    cyc(); p0_we = 0; p0_wdata = 0; p0_addr = 32'h6;
    exp_q.push_back('{0, 32'h0, cyc_n + 1});
    @(negedge clk);
    checks++;
    if (p0_err !== 1'b1 || p0_gnt !== 1'b1 || ram_we !== 1'b0) begin
      errors++; $display("FAIL err_wr_pulse: got err=%b gnt=%b we=%b, required 1 1 0", p0_err, p0_gnt, ram_we);
    end
    cyc(); idle();
    @(negedge clk);
    checks++;
    if (p0_err !== 1'b1) begin
      errors++; $display("FAIL err_rd_pulse: got %b, required 1", p0_err);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (p0_err !== 1'b0 || mem[0] !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL err_clear: got err=%b mem0=%h, required err=0 mem0=0badf00d", p0_err, mem[0]);
    end
  endtask

  task automatic test_rr_fixed();
    logic w;
    cyc(); reset = 1'b1; idle();
    cyc(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_addr = 32'h20;
      w = (i % 2 == 1);
      exp_q.push_back('{int'(w), w ? 32'h12345678 : 32'hDEADBEEF, cyc_n + 1});
      @(negedge clk);
      checks++;
      if (p0_gnt !== ~w || p1_gnt !== w) begin
        errors++; $display("FAIL rr_gnt[%0d]: got p0=%b p1=%b, required p0=%b p1=%b", i, p0_gnt, p1_gnt, ~w, w);
      end
      checks++;
      if (f0_gnt !== 1'b1 || f1_gnt !== 1'b0) begin
        errors++; $display("FAIL fixed_gnt[%0d]: got p0=%b p1=%b, required p0=1 p1=0", i, f0_gnt, f1_gnt);
      end
    end
    cyc(); idle();
    cyc();
  endtask

  task automatic test_lock_burst();
    int  n1 = 0;
    int  j  = 0;
    logic w0;
    while (n1 < 40 && j < 80) begin
      cyc();
      p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 32'h100 + 32'(4 * n1); p1_wdata = 32'(n1);
      p0_req = (j > 0); p0_we = 1; p0_addr = 32'h400; p0_wdata = 32'h5A5A_5A5A;
      w0 = (j % 17 == 16);
      @(negedge clk);
      checks++;
      if (p0_gnt !== w0 || p1_gnt !== ~w0) begin
        errors++; $display("FAIL lock_burst[%0d]: got p0=%b p1=%b, required p0=%b p1=%b", j, p0_gnt, p1_gnt, w0, ~w0);
      end
      if (!w0) n1++;
      j++;
    end
    cyc(); idle();
    @(negedge clk);
    checks++;
    if (j !== 42 || mem[103] !== 32'd39 || mem[256] !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL lock_burst_end: got cycles=%0d mem103=%h mem256=%h, required 42 00000027 5a5a5a5a", j, mem[103], mem[256]);
    end
  endtask

  task automatic test_lock_idle();
    for (int n = 0; n < 40; n++) begin
      cyc();
      p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 32'h100 + 32'(4 * n); p1_wdata = 32'h1000 + 32'(n);
      @(negedge clk);
      checks++;
      if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || ram_we !== 1'b1) begin
        errors++; $display("FAIL lock_idle[%0d]: got p1=%b p0=%b we=%b, required 1 0 1", n, p1_gnt, p0_gnt, ram_we);
      end
    end
    cyc(); idle();
    @(negedge clk);
    checks++;
    if (mem[64] !== 32'h1000 || mem[103] !== 32'h1027) begin
      errors++; $display("FAIL lock_idle_mem: got mem64=%h mem103=%h, required 00001000 00001027", mem[64], mem[103]);
    end
  endtask

  task automatic test_reset_midop();
    mon_off = 1'b1;
    cyc(); p1_req = 1; p1_we = 0; p1_lock = 1; p1_addr = 32'h20;
    @(negedge clk);
    checks++;
    if (p1_gnt !== 1'b1) begin
      errors++; $display("FAIL midrst_gnt: got %b, required 1", p1_gnt);
    end
    cyc(); reset = 1'b1; idle();
    cyc();
    @(negedge clk);
    checks++;
    if ({p1_rvalid, p1_err, p1_gnt, p0_gnt} !== 4'b0 || p1_rdata !== 32'd0) begin
      errors++; $display("FAIL midrst_out: got rv/err/g1/g0=%b rdata=%h, required 0000 0", {p1_rvalid, p1_err, p1_gnt, p0_gnt}, p1_rdata);
    end
    cyc(); reset = 1'b0; mon_off = 1'b0;
    p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_addr = 32'h20;
    exp_q.push_back('{0, 32'hDEADBEEF, cyc_n + 1});
    @(negedge clk);
    checks++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      errors++; $display("FAIL midrst_tie: got p0=%b p1=%b, required p0=1 p1=0", p0_gnt, p1_gnt);
    end
    cyc(); idle();
    cyc();
  endtask

  initial begin
    mem[0] = 32'h0BAD_F00D;
    mem[1] = 32'hAAAA_5555;
    mem[4] = 32'hDEAD_BEEF;
    reset = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_write_read();
    test_errors();
    test_rr_fixed();
    test_lock_burst();
    test_lock_idle();
    test_reset_midop();
    cyc();
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
